// File: rtl/mem_access_unit.sv
// MAR/MDR/IR holder with a wait-stated read/write handshake to a synchronous RAM.
// Optional MAU_AUTO_INC_EN: MAR post-increments when an access completes.
module mem_access_unit #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned OPCODE_WIDTH = 5,
    parameter int unsigned WAIT_STATES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mar_sclr,
    input  logic                    ir_sclr,
    input  logic                    mar_en,
    input  logic [DATA_WIDTH-1:0]   busC,
    input  logic [DATA_WIDTH-1:0]   bus_alu,
    input  logic                    mdr_alu_n,
    input  logic                    mdr_en,
    input  logic                    start,
    input  logic                    wr_rdn,
    input  logic                    ir_en,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    output logic [ADDR_WIDTH-1:0]   mar,
    output logic [DATA_WIDTH-1:0]   mdr,
    output logic [OPCODE_WIDTH-1:0] instruction,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] COMPLETE = 2'd2;

`ifdef MAU_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    logic [1:0]            state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  op_wr, op_wr_nxt;
    logic                  op_ir, op_ir_nxt;
    logic                  capture;
    logic                  rd_capture;
    logic                  in_busy;
    logic                  ir_wr_pending;
    logic [DATA_WIDTH-1:0] ir;
    logic [ADDR_WIDTH-1:0] mar_nxt;
    logic [DATA_WIDTH-1:0] mdr_nxt;
    logic [DATA_WIDTH-1:0] ir_nxt;
    logic                  unused_busc;

    // Only the low address bits of busC reach MAR.
    assign unused_busc = ^busC;

    assign mem_addr    = mar;
    assign mem_wdata   = mdr;
    assign instruction = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];

    // Next-state, counter and op latching.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_wr_nxt = op_wr;
        op_ir_nxt = op_ir;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CNT_W'(WAIT_STATES);
                    op_wr_nxt = wr_rdn;
                    op_ir_nxt = ir_en;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = COMPLETE;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            COMPLETE: begin
                if (start) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = CNT_W'(WAIT_STATES);
                    op_wr_nxt = wr_rdn;
                    op_ir_nxt = ir_en;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_busy       = (state != IDLE);
    assign rd_capture    = capture && !op_wr;
    assign ir_wr_pending = (state == ACCESS) && !op_wr && op_ir;

    // Datapath register updates; address and write data frozen while busy.
    always_comb begin
        mar_nxt = mar;
        mdr_nxt = mdr;
        ir_nxt  = ir;
        if (!in_busy) begin
            if (mar_sclr)    mar_nxt = '0;
            else if (mar_en) mar_nxt = busC[ADDR_WIDTH-1:0];
        end else if (capture && AUTO_INC) begin
            mar_nxt = mar + ADDR_WIDTH'(1);
        end
        if (rd_capture && mdr_alu_n)                mdr_nxt = mem_rdata;
        else if (!in_busy && mdr_en && !mdr_alu_n)  mdr_nxt = bus_alu;
        if (ir_sclr && !(in_busy && ir_wr_pending)) ir_nxt = '0;
        else if (rd_capture && op_ir)               ir_nxt = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            op_ir   <= 1'b0;
            mar     <= '0;
            mdr     <= '0;
            ir      <= '0;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op_wr   <= op_wr_nxt;
            op_ir   <= op_ir_nxt;
            mar     <= mar_nxt;
            mdr     <= mdr_nxt;
            ir      <= ir_nxt;
            mem_we  <= (state_nxt == ACCESS) && op_wr_nxt;
            mem_re  <= (state_nxt == ACCESS) && !op_wr_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == COMPLETE);
            overrun <= overrun | ((state == ACCESS) && start);
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected access results queued at launch, checked on done.
module tb_mem_access_unit;

    localparam int unsigned WS = 2;
`ifdef MAU_AUTO_INC_EN
    localparam logic [7:0] AINC = 8'd1;
`else
    localparam logic [7:0] AINC = 8'd0;
`endif

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] mar_after;
        logic [7:0] mdr;
        logic [4:0] instr;
        int         done_cyc;
    } exp_t;

    logic       clk, rst, mar_sclr, ir_sclr, mar_en, mdr_alu_n, mdr_en;
    logic       start, wr_rdn, ir_en;
    logic [7:0] busC, bus_alu, mem_rdata;
    logic [7:0] mem_addr, mem_wdata, mar, mdr;
    logic       mem_we, mem_re, busy, done, overrun;
    logic [4:0] instruction;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    exp_t sb[$];

    logic [7:0] m_mar, m_mdr;
    logic [4:0] m_instr;

    mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .OPCODE_WIDTH(5), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .mar_sclr(mar_sclr), .ir_sclr(ir_sclr), .mar_en(mar_en),
        .busC(busC), .bus_alu(bus_alu), .mdr_alu_n(mdr_alu_n), .mdr_en(mdr_en),
        .start(start), .wr_rdn(wr_rdn), .ir_en(ir_en), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mar(mar), .mdr(mdr), .instruction(instruction), .busy(busy), .done(done),
        .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Strobe-window monitor plus scoreboard pop on each done pulse.
    int         run = 0, last_run = 0;
    logic [7:0] run_addr, run_wd;
    logic       run_we, run_stable;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (mem_re || mem_we)) begin
            if (run == 0) begin
                run_addr   = mem_addr;
                run_wd     = mem_wdata;
                run_we     = mem_we;
                run_stable = 1'b1;
            end else if (mem_addr !== run_addr || mem_wdata !== run_wd) begin
                run_stable = 1'b0;
            end
            run++;
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_len", 32'(last_run), 32'(WS + 1));
                check("strobe_we", 32'(run_we), 32'(e.we));
                check("acc_addr", 32'(run_addr), 32'(e.addr));
                check("addr_wd_stable", 32'(run_stable), 32'd1);
                check("mdr", 32'(mdr), 32'(e.mdr));
                check("instruction", 32'(instruction), 32'(e.instr));
                check("mar_after", 32'(mar), 32'(e.mar_after));
                check("done_latency", 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse and queue the expected outcome from the bench model.
    task automatic launch(input logic wr, input logic ld_ir);
        exp_t e;
        e.we   = wr;
        e.addr = m_mar;
        if (!wr) begin
            if (mdr_alu_n) m_mdr = mem_rdata;
            if (ld_ir)     m_instr = mem_rdata[7:3];
        end
        m_mar       = m_mar + AINC;
        e.mar_after = m_mar;
        e.mdr       = m_mdr;
        e.instr     = m_instr;
        e.done_cyc  = cyc + 1 + int'(WS) + 1;
        sb.push_back(e);
        start  = 1'b1;
        wr_rdn = wr;
        ir_en  = ld_ir;
        tick();
        start  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mar"}, 32'(mar), 32'd0);
        check({tag, "_mdr"}, 32'(mdr), 32'd0);
        check({tag, "_instr"}, 32'(instruction), 32'd0);
        check({tag, "_strobes"}, {30'd0, mem_we, mem_re}, 32'd0);
        check({tag, "_flags"}, {29'd0, busy, done, overrun}, 32'd0);
    endtask

    initial begin
        logic [7:0] a;
        int n;
        rst = 1'b1; mar_sclr = 0; ir_sclr = 0; mar_en = 0; mdr_en = 0; mdr_alu_n = 1;
        start = 0; wr_rdn = 0; ir_en = 0; busC = 0; bus_alu = 0; mem_rdata = 0;
        m_mar = 0; m_mdr = 0; m_instr = 0;
        #22;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Write 0xA5 to 0x3C
        busC = 8'h3C; mar_en = 1; tick(); mar_en = 0; m_mar = 8'h3C;
        check("mar_load", 32'(mar), 32'h3C);
        bus_alu = 8'hA5; mdr_alu_n = 0; mdr_en = 1; tick(); mdr_en = 0; m_mdr = 8'hA5;
        check("mdr_load", 32'(mdr), 32'hA5);
        launch(1'b1, 1'b0);
        check("busy_write", 32'(busy), 32'd1);
        drain();

        // Read with IR load
        mem_rdata = 8'hB7; mdr_alu_n = 1;
        launch(1'b0, 1'b1);
        drain();
        check("instr_b7", 32'(instruction), 32'h16);

        // Back-to-back and overrun
        mem_rdata = 8'h5A;
        launch(1'b0, 1'b0);
        n = 0;
        while (!done && n < 50) begin tick(); n++; end
        check("reach_complete", 32'(done), 32'd1);
        mem_rdata = 8'hC3;
        launch(1'b0, 1'b0);
        check("b2b_re", 32'(mem_re), 32'd1);
        check("overrun_pre", 32'(overrun), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        drain();
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Gating of MAR/MDR while busy
        busC = 8'h20; mar_en = 1; tick(); mar_en = 0; m_mar = 8'h20;
        bus_alu = 8'h77; mdr_alu_n = 0; mdr_en = 1; tick(); mdr_en = 0; m_mdr = 8'h77;
        a = m_mar;
        launch(1'b1, 1'b0);
        busC = 8'h11; mar_en = 1; bus_alu = 8'hEE; mdr_en = 1; tick();
        mar_en = 0; mar_sclr = 1; tick();
        mar_sclr = 0; mdr_en = 0; mdr_alu_n = 1;
        check("gate_mar", 32'(mar), 32'(a));
        check("gate_mdr", 32'(mdr), 32'h77);
        drain();

        // IR clear: honoured when idle, ignored while the access loads IR
        ir_sclr = 1; tick(); ir_sclr = 0; m_instr = 0;
        check("ir_sclr_idle", 32'(instruction), 32'd0);
        mem_rdata = 8'h9C;
        launch(1'b0, 1'b1);
        ir_sclr = 1; tick(); ir_sclr = 0;
        drain();

`ifdef MAU_AUTO_INC_EN
        busC = 8'hFF; mar_en = 1; tick(); mar_en = 0; m_mar = 8'hFF;
        mem_rdata = 8'h42;
        launch(1'b0, 1'b0);
        drain();
        check("autoinc_wrap", 32'(mar), 32'h00);
        launch(1'b0, 1'b0);
        drain();
        check("autoinc_next", 32'(mar), 32'h01);
`endif

        // Reset mid-access: strobe must drop without a clock edge
        mem_rdata = 8'hE1;
        launch(1'b0, 1'b1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_async_re", 32'(mem_re), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        sb.delete();
        #17 rst = 1'b0;
        check_all_zero("rst_mid");
        m_mar = 0; m_mdr = 0; m_instr = 0;
        tick();

        // Recovery read after reset
        mem_rdata = 8'h3F;
        launch(1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
